// File: rtl/bist_pkg.sv
// Shared definitions for the scan BIST sequencer and the BIST wrapper that
// instantiates it: FSM state encoding and default chain/pattern sizes.
package bist_pkg;

    localparam int BIST_CHAIN_LEN    = 16;
    localparam int BIST_NUM_PATTERNS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT,
        ST_CAPTURE,
        ST_FLUSH,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    // INIT through COMPARE make up one run.
    function automatic logic state_is_busy(input bist_state_t s);
        return (s == ST_INIT) || (s == ST_SHIFT) || (s == ST_CAPTURE) ||
               (s == ST_FLUSH) || (s == ST_COMPARE);
    endfunction

endpackage

// File: rtl/bist_step_counter.sv
// Step counter with synchronous clear, increment enable and a terminal-count
// flag at LAST. With WRAP set, an increment at LAST returns the count to zero.
module bist_step_counter #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] LAST  = '1,
    parameter bit               WRAP  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    assign last = (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= (WRAP && last) ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// Scan BIST sequencer: INIT, CHAIN_LEN-cycle shifts and captures per pattern,
// a final flush, then a sticky pass/done result. Optional `BIST_CTRL_ABORT_EN
// adds an abort input that ends a run early with a failing result.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int CHAIN_LEN    = BIST_CHAIN_LEN,
    parameter int NUM_PATTERNS = BIST_NUM_PATTERNS
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic pass_nfail,
`ifdef BIST_CTRL_ABORT_EN
    input  logic abort,
`endif
    output logic misr_reset,
    output logic misr_enable,
    output logic lfsr_load,
    output logic scan_enable,
    output logic capture,
    output logic busy,
    output logic done,
    output logic pass
);

    localparam int SHIFT_W = $clog2(CHAIN_LEN);
    localparam int PAT_W   = $clog2(NUM_PATTERNS + 1);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);

    bist_state_t state, state_next;
    logic pass_next;

    logic [SHIFT_W-1:0] shift_cnt;
    logic [PAT_W-1:0]   pat_cnt;
    logic shift_last, pat_last;
    logic abort_hit;

    // Shift counter wraps on its own at the end of every SHIFT/FLUSH burst.
    bist_step_counter #(
        .WIDTH (SHIFT_W),
        .LAST  (SHIFT_LAST),
        .WRAP  (1'b1)
    ) u_shift_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state == ST_INIT),
        .inc   ((state == ST_SHIFT) || (state == ST_FLUSH)),
        .count (shift_cnt),
        .last  (shift_last)
    );

    bist_step_counter #(
        .WIDTH (PAT_W),
        .LAST  (PAT_LAST),
        .WRAP  (1'b0)
    ) u_pat_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state == ST_INIT),
        .inc   (state == ST_CAPTURE),
        .count (pat_cnt),
        .last  (pat_last)
    );

    // Counter values are kept for observability; control uses only the flags.
    logic unused_cnt;
    assign unused_cnt = ^{shift_cnt, pat_cnt};

`ifdef BIST_CTRL_ABORT_EN
    assign abort_hit = abort && state_is_busy(state);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            pass  <= 1'b0;
        end else begin
            state <= state_next;
            pass  <= pass_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (start) state_next = ST_INIT;
            ST_INIT:    state_next = ST_SHIFT;
            ST_SHIFT:   if (shift_last) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = pat_last ? ST_FLUSH : ST_SHIFT;
            ST_FLUSH:   if (shift_last) state_next = ST_COMPARE;
            ST_COMPARE: state_next = ST_DONE;
            ST_DONE:    if (start) state_next = ST_INIT;
            default:    state_next = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_next = ST_DONE;
        end
    end

    // The result is dropped on the way into INIT so a rerun never shows a stale pass.
    always_comb begin
        pass_next = pass;
        if (abort_hit) begin
            pass_next = 1'b0;
        end else if (state == ST_COMPARE) begin
            pass_next = pass_nfail;
        end else if (state_next == ST_INIT) begin
            pass_next = 1'b0;
        end
    end

    always_comb begin
        misr_reset  = (state == ST_INIT);
        lfsr_load   = (state == ST_INIT);
        scan_enable = (state == ST_SHIFT) || (state == ST_FLUSH);
        misr_enable = (state == ST_SHIFT) || (state == ST_FLUSH);
        capture     = (state == ST_CAPTURE);
        busy        = state_is_busy(state);
        done        = (state == ST_DONE);
    end

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

Sequencer for the scan-based BIST engine. Accepts a single start request, walks the scan chain through a fixed number of shift/capture patterns, and drives the MISR's clear and accumulate controls. After a final flush it samples the MISR's golden-signature comparison into a sticky pass/done result. It sits between the test-access logic (start/result) and the scan chain, pattern LFSR and MISR datapath.

## Interface
- `CHAIN_LEN`, 16 — scan chain length; shift cycles per pattern; legal range ≥2.
- `NUM_PATTERNS`, 64 — number of shift/capture patterns; legal range ≥1.
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — level-sampled run request.
- `pass_nfail` in 1 — MISR signature equals the golden value (combinational from MISR).
- `misr_reset` out 1 — MISR synchronous clear.
- `misr_enable` out 1 — MISR accumulate.
- `lfsr_load` out 1 — load the seed into the pattern LFSR.
- `scan_enable` out 1 — chain in shift mode; LFSR advances.
- `capture` out 1 — one-cycle functional capture into the chain.
- `busy` out 1 — run in progress.
- `done` out 1 — result valid, sticky.
- `pass` out 1 — run passed; valid only while `done`=1.

## Operation
- States: IDLE, INIT, SHIFT, CAPTURE, FLUSH, COMPARE, DONE.
- IDLE: `start`=1 → INIT.
- INIT (1 cycle): `misr_reset`=1, `lfsr_load`=1. Clears `shift_cnt` and `pat_cnt`, then → SHIFT.
- SHIFT (`CHAIN_LEN` cycles): `scan_enable`=1, `misr_enable`=1. On the last shift cycle → CAPTURE.
- CAPTURE (1 cycle): `capture`=1, `pat_cnt`++. Next state is FLUSH if `pat_cnt` was `NUM_PATTERNS`-1, otherwise SHIFT.
- FLUSH (`CHAIN_LEN` cycles): `scan_enable`=1, `misr_enable`=1. Unloads the last response, then → COMPARE.
- COMPARE (1 cycle): registers `pass_nfail` into `pass`, then → DONE.
- DONE: `done`=1. `pass` holds. `start`=1 → INIT (rerun; clears `done` and `pass` on entry to INIT).
- `busy`=1 in INIT through COMPARE.
- `start` is ignored outside IDLE and DONE.
- All outputs except `pass` are a decode of the registered state only. No combinational path from any input to any output.
- Counter widths:
  - `shift_cnt` is $clog2(CHAIN_LEN) bits and wraps to 0 at SHIFT/FLUSH exit.
  - `pat_cnt` is $clog2(NUM_PATTERNS+1) bits.
  - No overflow is possible within the legal parameter range.
- `reset` at any time, including mid-run, forces IDLE.

## Timing
- Reset values: every output 0, state IDLE, both counters 0.
- `start` high in cycle 0 (state IDLE) puts INIT in cycle 1. Pattern k (0-based):
  - SHIFT in cycles 2+k·(CHAIN_LEN+1) through 1+CHAIN_LEN+k·(CHAIN_LEN+1).
  - CAPTURE in the cycle after the last SHIFT cycle.
- Total length: with R = 1 + NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN + 1, `done` rises at cycle R+1.
  - Defaults: R = 1106, `done` first high at cycle 1107.
- `misr_enable` total high cycles per run = (NUM_PATTERNS+1)·CHAIN_LEN.
- `pass` samples the signature in COMPARE, one cycle after the last MISR update has registered.
- `start` held high continuously gives back-to-back runs. DONE lasts exactly 1 cycle, then INIT.

## Configuration
- Macro: `BIST_CTRL_ABORT_EN`.
- Defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in any state INIT through COMPARE → DONE next cycle with `pass`=0.
  - `abort` takes priority over every other transition.
  - `abort` in IDLE or DONE is ignored.
- Undefined: no `abort` port; runs always complete.

## Structure
- Shared package `bist_pkg`:
  - `bist_state_t` enum (7 states).
  - Default constants `BIST_CHAIN_LEN` = 16 and `BIST_NUM_PATTERNS` = 64, which the top-level BIST wrapper also uses.
- One sub-module, `bist_step_counter`:
  - Parameterised-width counter with synchronous clear, increment enable and terminal-count flag.
  - Instantiated twice: shift counter and pattern counter.
- FSM and output decode live in `bist_ctrl`.

## Test plan
- **Reset/idle:** `reset` for 2 cycles, `start`=0 for 20 cycles → all outputs 0, state IDLE.
- **Full run, CHAIN_LEN=4, NUM_PATTERNS=2, `pass_nfail`=1 throughout:**
  - INIT at cycle 1.
  - `capture` at cycles 6 and 11.
  - FLUSH at cycles 12–15.
  - `misr_enable` high for exactly 12 cycles.
  - `done`=1 and `pass`=1 at cycle 17, both held while `start`=0.
- **Fail path, same config:** `pass_nfail`=0 only during the COMPARE cycle (16) → `done`=1, `pass`=0.
- **Defaults:** `start` pulse → `done` first high at cycle 1107. `capture` counted 64 times, `misr_enable` counted 1040 times.
- **Mid-run reset:** `reset` at cycle 8 → all outputs 0 at cycle 9. A new `start` repeats the exact timeline from INIT. `start` pulses during busy cycles 3–10 are ignored.
- **Abort (`BIST_CTRL_ABORT_EN` defined):**
  - `abort` at cycle 7 with `pass_nfail`=1 → DONE at cycle 8 with `pass`=0, `busy`=0.
  - `start` at cycle 9 → INIT at cycle 10, `done`=0.
